// File: rtl/alu_seq.sv
// Sequenced ALU: single-cycle logic/arith ops, WIDTH-cycle shift-add multiply,
// registered result and {V,N,Z,C} flags, tri-stated result bus.
// state | meaning
// IDLE  | waiting for start
// EXEC  | one-cycle ALU op, result written on exit
// MUL   | shift-add multiply, one partial product per cycle
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             bus_enable_n,
  input  logic             flag_fi_n,
  input  logic             flag_clear_n,
  output logic [WIDTH-1:0] bus_out,
  output logic             busy,
  output logic             done,
  output logic [3:0]       flag_out
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                         OP_XOR = 3'd4, OP_SHL = 3'd5, OP_SHR = 3'd6, OP_MUL = 3'd7;

  typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, result;
  logic [2:0]       op_q;
  logic [WIDTH:0]   mul_hi;
  logic [WIDTH-1:0] mul_lo;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c, alu_v;
  logic [WIDTH:0]   mul_sum;
  logic [2*WIDTH:0] mul_next;
  logic             fin_valid;
  logic [WIDTH-1:0] fin_r;
  logic             fin_c, fin_v;
  logic [3:0]       fin_flags;

  always_comb begin
    sum   = '0;
    alu_r = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op_q)
      OP_ADD: begin
        sum   = {1'b0, a_q} + {1'b0, b_q};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (alu_r[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        sum   = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        alu_r = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
        alu_v = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (alu_r[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_AND: alu_r = a_q & b_q;
      OP_OR:  alu_r = a_q | b_q;
      OP_XOR: alu_r = a_q ^ b_q;
      OP_SHL: begin
        alu_r = {a_q[WIDTH-2:0], 1'b0};
        alu_c = a_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_r = {1'b0, a_q[WIDTH-1:1]};
        alu_c = a_q[0];
      end
      default: ;
    endcase
  end

  // Product accumulates as {mul_hi, mul_lo}; the multiplier shifts out of mul_lo.
  always_comb begin
    mul_sum  = mul_lo[0] ? (mul_hi + {1'b0, a_q}) : mul_hi;
    mul_next = {mul_sum, mul_lo} >> 1;
  end

  always_comb begin
    fin_valid = 1'b0;
    fin_r     = alu_r;
    fin_c     = alu_c;
    fin_v     = alu_v;
    if (state == EXEC) begin
      fin_valid = 1'b1;
    end else if (state == MUL && cnt == '0) begin
      fin_valid = 1'b1;
      fin_r     = mul_next[WIDTH-1:0];
      fin_c     = |mul_next[2*WIDTH:WIDTH];
      fin_v     = 1'b0;
    end
    fin_flags = {fin_v, fin_r[WIDTH-1], (fin_r == '0), fin_c};
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result   <= '0;
      flag_out <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mul_hi   <= '0;
      mul_lo   <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      if (!flag_clear_n)
        flag_out <= '0;
      else if (fin_valid && !flag_fi_n)
        flag_out <= fin_flags;

      case (state)
        IDLE: begin
          if (start) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            busy <= 1'b1;
            if (op == OP_MUL) begin
              state  <= MUL;
              mul_hi <= '0;
              mul_lo <= b;
              cnt    <= CW'(WIDTH - 1);
            end else begin
              state <= EXEC;
            end
          end
        end
        EXEC: begin
          result <= fin_r;
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        MUL: begin
          mul_hi <= mul_next[2*WIDTH:WIDTH];
          mul_lo <= mul_next[WIDTH-1:0];
          if (cnt == '0) begin
            result <= fin_r;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_out = bus_enable_n ? {WIDTH{1'bz}} : result;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq (WIDTH=8): expected result/flags queued at
// start, popped and compared when done is seen.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       clr, start, bus_enable_n, flag_fi_n, flag_clear_n;
  logic [7:0] a, b;
  logic [2:0] op;
  wire  [7:0] bus_out;
  logic       busy, done;
  logic [3:0] flag_out;

  logic       tb_bus_en = 1'b0;
  logic [7:0] tb_bus_val = 8'h00;
  assign bus_out = tb_bus_en ? tb_bus_val : 8'bz;

  int n_tests = 0;
  int n_fail  = 0;
  logic [3:0]  exp_flags = 4'h0;
  logic [11:0] sb_q[$];

  alu_seq #(.WIDTH(8)) dut (
    .clk(clk), .clr(clr), .a(a), .b(b), .op(op), .start(start),
    .bus_enable_n(bus_enable_n), .flag_fi_n(flag_fi_n), .flag_clear_n(flag_clear_n),
    .bus_out(bus_out), .busy(busy), .done(done), .flag_out(flag_out)
  );

  always #5 clk = ~clk;

  // Returns {V,N,Z,C,R[7:0]}.
  function automatic logic [11:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
    int s, ss;
    logic [7:0] r, ny;
    logic c, v;
    s = 0; ss = 0; r = 8'h00; c = 1'b0; v = 1'b0; ny = ~y;
    case (o)
      3'd0: begin
        s = int'(x) + int'(y);
        ss = int'($signed(x)) + int'($signed(y));
        r = s[7:0]; c = (s > 255); v = (ss > 127) || (ss < -128);
      end
      3'd1: begin
        s = int'(x) + int'(ny) + 1;
        ss = int'($signed(x)) - int'($signed(y));
        r = s[7:0]; c = (s > 255); v = (ss > 127) || (ss < -128);
      end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x ^ y;
      3'd5: begin r = {x[6:0], 1'b0}; c = x[7]; end
      3'd6: begin r = {1'b0, x[7:1]}; c = x[0]; end
      default: begin
        s = int'(x) * int'(y);
        r = s[7:0]; c = (s > 255);
      end
    endcase
    return {v, r[7], (r == 8'h00), c, r};
  endfunction

  // Issue one op at a negedge, wait for done, compare against the scoreboard.
  task automatic do_op(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                       input logic fi, input logic fclr, input int lat, input logic inject);
    logic [11:0] m, e;
    int k;
    logic got;
    m = model(o, x, y);
    if (!fclr) exp_flags = 4'h0;
    else if (!fi) exp_flags = m[11:8];
    sb_q.push_back({exp_flags, m[7:0]});
    op = o; a = x; b = y; flag_fi_n = fi; flag_clear_n = fclr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tests++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start op=%0d got=%b want=1", o, busy); end
    k = 1; got = 1'b0;
    while (k < 40 && !got) begin
      if (done === 1'b1) got = 1'b1;
      else begin
        if (inject && k == 3) begin start = 1'b1; op = 3'd0; a = 8'hFF; b = 8'hFF; end
        else start = 1'b0;
        @(negedge clk);
        k++;
      end
    end
    start = 1'b0;
    e = sb_q.pop_front();
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL done_timeout op=%0d waited=%0d cycles", o, k);
    end else begin
      if (k - 1 !== lat) begin n_fail++; $display("FAIL latency op=%0d got=%0d want=%0d", o, k - 1, lat); end
      n_tests++;
      if (bus_out !== e[7:0]) begin n_fail++; $display("FAIL result op=%0d a=%h b=%h got=%h want=%h", o, x, y, bus_out, e[7:0]); end
      n_tests++;
      if (flag_out !== e[11:8]) begin n_fail++; $display("FAIL flags op=%0d a=%h b=%h got=%b want=%b", o, x, y, flag_out, e[11:8]); end
      n_tests++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_done op=%0d got=%b want=0", o, busy); end
    end
    flag_clear_n = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00; op = 3'd0;
    bus_enable_n = 1'b0; flag_fi_n = 1'b1; flag_clear_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_tests++;
    if ({busy, done, flag_out, bus_out} !== 14'h0)
      begin n_fail++; $display("FAIL reset_state got busy=%b done=%b flags=%b bus=%h want all 0", busy, done, flag_out, bus_out); end
    clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add();
    do_op(3'd0, 8'h7F, 8'h01, 1'b0, 1'b1, 1, 1'b0);  // flags 1100
    do_op(3'd0, 8'hFF, 8'h01, 1'b0, 1'b1, 1, 1'b0);  // carry, zero
  endtask

  task automatic test_sub();
    do_op(3'd1, 8'h05, 8'h05, 1'b0, 1'b1, 1, 1'b0);
    do_op(3'd1, 8'h03, 8'h05, 1'b0, 1'b1, 1, 1'b0);
    do_op(3'd1, 8'h80, 8'h01, 1'b0, 1'b1, 1, 1'b0);
  endtask

  task automatic test_mul();
    do_op(3'd7, 8'h10, 8'h11, 1'b0, 1'b1, 8, 1'b1);
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0)
      begin n_fail++; $display("FAIL mul_no_queued_start got done=%b busy=%b want 0 0", done, busy); end
    do_op(3'd7, 8'hFF, 8'hFF, 1'b0, 1'b1, 8, 1'b0);
    do_op(3'd7, 8'h0D, 8'h0B, 1'b0, 1'b1, 8, 1'b0);
  endtask

  task automatic test_shr_flags();
    do_op(3'd5, 8'hC1, 8'h00, 1'b0, 1'b1, 1, 1'b0);
    do_op(3'd6, 8'h01, 8'h00, 1'b1, 1'b1, 1, 1'b0);
    do_op(3'd6, 8'h01, 8'h00, 1'b0, 1'b1, 1, 1'b0);
  endtask

  task automatic test_clr_mid_mul();
    logic seen;
    do_op(3'd0, 8'h7F, 8'h01, 1'b0, 1'b1, 1, 1'b0);
    op = 3'd7; a = 8'h10; b = 8'h11; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    exp_flags = 4'h0;
    n_tests++;
    if ({busy, done, flag_out, bus_out} !== 14'h0)
      begin n_fail++; $display("FAIL clr_abort got busy=%b done=%b flags=%b bus=%h want all 0", busy, done, flag_out, bus_out); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL clr_abort_no_done got done=1 want 0"); end
  endtask

  task automatic test_clr_start_priority();
    op = 3'd0; a = 8'h01; b = 8'h01; start = 1'b1; clr = 1'b1;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_over_start busy got=%b want=0", busy); end
    @(negedge clk);
    n_tests++;
    if (done !== 1'b0 || bus_out !== 8'h00)
      begin n_fail++; $display("FAIL clr_over_start result got done=%b bus=%h want 0 00", done, bus_out); end
  endtask

  task automatic test_bus_and_clear();
    do_op(3'd3, 8'hA0, 8'h05, 1'b0, 1'b1, 1, 1'b0);
    bus_enable_n = 1'b1; tb_bus_en = 1'b1; tb_bus_val = 8'h00;
    @(negedge clk);
    n_tests++;
    if (bus_out !== 8'h00) begin n_fail++; $display("FAIL bus_hiz_low got=%h want=00", bus_out); end
    tb_bus_val = 8'hFF;
    @(negedge clk);
    n_tests++;
    if (bus_out !== 8'hFF) begin n_fail++; $display("FAIL bus_hiz_high got=%h want=ff", bus_out); end
    tb_bus_en = 1'b0; bus_enable_n = 1'b0;
    @(negedge clk);
    n_tests++;
    if (bus_out !== 8'hA5) begin n_fail++; $display("FAIL bus_reenable got=%h want=a5", bus_out); end
    do_op(3'd0, 8'h7F, 8'h01, 1'b0, 1'b1, 1, 1'b0);
    do_op(3'd0, 8'h7F, 8'h01, 1'b0, 1'b0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [2:0] o;
    for (int i = 0; i < 16; i++) begin
      o = 3'($urandom_range(0, 7));
      do_op(o, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1, (o == 3'd7) ? 8 : 1, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_shr_flags();
    test_clr_mid_mul();
    test_clr_start_priority();
    test_bus_and_clear();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; legal range 4..32.
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 clr  in  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 a  in  WIDTH  operand A.
REQ-005 b  in  WIDTH  operand B.
REQ-006 op  in  3  operation select: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL.
REQ-007 start  in  1  single-cycle request; a, b, op sampled on the same edge.
REQ-008 bus_enable_n  in  1  active-low bus drive enable.
REQ-009 flag_fi_n  in  1  active-low flag load enable, sampled when a result completes.
REQ-010 flag_clear_n  in  1  active-low synchronous flag clear.
REQ-011 bus_out  out  WIDTH  result register when bus_enable_n=0, else all bits high-Z.
REQ-012 busy  out  1  high while an operation is in progress.
REQ-013 done  out  1  one-cycle pulse when the result register updates.
REQ-014 flag_out  out  4  registered flags {V,N,Z,C}, bit0=C.

Function
REQ-015 FSM states: IDLE, EXEC, MUL; reset state IDLE.
REQ-016 IDLE + start + op!=7 -> EXEC; result computed from sampled operands, written on the next edge; done=1 that cycle; returns to IDLE; latency 1 cycle start-to-done.
REQ-017 IDLE + start + op=7 -> MUL; shift-add over exactly WIDTH cycles; done pulses on cycle WIDTH after start; returns to IDLE.
REQ-018 busy=1 in EXEC and MUL, 0 in IDLE; start while busy=1 is ignored, no queuing.
REQ-019 ADD: {C,R}=A+B, WIDTH+1-bit sum; SUB: R=A+~B+1, C=carry-out (1 = no borrow).
REQ-020 V for ADD/SUB: signed two's-complement overflow of R; V=0 for all other ops.
REQ-021 AND/OR/XOR: bitwise, C=0.
REQ-022 SHL: R=A<<1, C=A[WIDTH-1]; SHR: logical, R=A>>1, C=A[0]; B ignored.
REQ-023 MUL: unsigned; R=low WIDTH bits of A*B; C=1 iff upper WIDTH bits nonzero.
REQ-024 Z=1 iff R==0; N=R[WIDTH-1]; for all ops.
REQ-025 Flag register loads {V,N,Z,C} only on the done cycle with flag_fi_n=0; otherwise holds.
REQ-026 flag_clear_n=0 clears flags to 0 on the edge and takes priority over a simultaneous load.
REQ-027 Result register holds last result until the next done; bus_enable_n never affects state.
REQ-028 Operand registers are captured at start; changes to a, b, op during MUL have no effect.

Reset
REQ-029 clr=1: state IDLE, result register 0, flags 0, busy 0, done 0, multiplier datapath cleared.
REQ-030 clr asserted mid-MUL aborts the operation; no done pulse; flags unchanged except clear to 0.
REQ-031 clr has priority over start on the same edge; start is discarded.

Verification (WIDTH=8)
REQ-032 ADD a=0x7F b=0x01, flag_fi_n=0 -> done next cycle, R=0x80, flags V=1 N=1 Z=0 C=0.
REQ-033 SUB a=0x05 b=0x05 -> R=0x00, Z=1 C=1 N=0 V=0; then a=0x03 b=0x05 -> R=0xFE, C=0 N=1.
REQ-034 MUL a=0x10 b=0x11 -> busy 8 cycles, done on cycle 8, R=0x10, C=1; start pulses during busy ignored.
REQ-035 SHR a=0x01 with flag_fi_n=1 -> R=0x00, flag_out unchanged; repeat with flag_fi_n=0 -> Z=1 C=1.
REQ-036 Start MUL, assert clr at cycle 4 -> busy=0 next cycle, no done, R=0x00, flags 0.
REQ-037 bus_enable_n=1 -> bus_out all Z; flag_clear_n=0 coincident with done and flag_fi_n=0 -> flags 0.
